uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receiver paired with the processor's UART transmit peripheral; deserialises 8N1 frames from the serial line into bytes.
- Buffers received bytes in a small FIFO that the core reads through the load path.
- A one-cycle read strobe pops one byte.
- Sits beside the transmit peripheral on the memory-mapped bus, off the single-cycle datapath's critical path.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 4..65535.
- FIFO_DEPTH, 16, entries in the receive FIFO; power of two, ≥2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- rx  input  1  serial line, idle high, asynchronous to clk.
- rd_en  input  1  pop strobe from the load path, one cycle per byte.
- rd_data  output  32  {24'b0, head byte}; 32'hFFFF_FFFF when FIFO empty.
- empty  output  1  FIFO holds no bytes.
- full  output  1  FIFO holds FIFO_DEPTH bytes.
- count  output  $clog2(FIFO_DEPTH)+1  bytes currently stored.
- frame_err  output  1  sticky; stop bit sampled low.
- overrun  output  1  sticky; byte dropped because FIFO full.
- clr_err  input  1  clears frame_err and overrun.

Behaviour:
- Reset (reset=0, async) forces:
  - FSM to IDLE; FIFO pointers and count to 0; empty=1, full=0.
  - frame_err=0, overrun=0.
  - rd_data=32'hFFFF_FFFF.
  - Both synchroniser flops to 1.
- rx passes through a 2-flop synchroniser; all logic uses the synchronised bit rx_s.
- FSM states:
  - IDLE: wait for rx_s=0.
  - START: count CLKS_PER_BIT/2 cycles, then resample. rx_s=1 is a glitch: return to IDLE, store nothing. rx_s=0 goes to DATA with the bit counter cleared.
  - DATA: every CLKS_PER_BIT cycles sample rx_s into the shift register, LSB first. After bit 7 go to STOP.
  - STOP: after CLKS_PER_BIT cycles sample rx_s.
    - rx_s=1: push the byte (or drop it, see below).
    - rx_s=0: set frame_err, discard the byte.
    - Then go to IDLE. IDLE requires rx_s=1 before a new start is detected, so a held-low line gives no repeated frames.
- Latency: byte visible (empty falls) on the cycle after the stop-bit sample, about 9.5 bit times after the start edge plus 2 synchroniser cycles.
- Push when FIFO full: byte dropped, FIFO unchanged, overrun set.
- Push with simultaneous pop when full: the pop frees the slot, so the push succeeds and overrun stays 0.
- rd_en when empty: ignored; pointers and count unchanged; rd_data stays 32'hFFFF_FFFF.
- rd_data is combinational from the head entry: the head byte is visible before rd_en, and the next entry appears the cycle after a pop.
- Simultaneous push and pop when not empty and not full: count unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH. count saturates logically at FIFO_DEPTH and never exceeds it.
- clr_err clears both sticky flags next cycle. An error event in the same cycle as clr_err wins (flag set).
- Reset mid-frame: partial byte discarded and FSM to IDLE. A frame in progress on release is ignored until rx_s returns high and falls again.

Decomposition:
- Shared package (uart_pkg) holds:
  - the rx FSM state enum {IDLE, START, DATA, STOP};
  - UART_DATA_BITS=8;
  - the empty-read constant 32'hFFFF_FFFF, so the transmit peripheral and the load-path mux use the same values.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count). It is reusable for the transmit-side buffer.
- The bit-timing FSM and synchroniser stay in uart_rx_fifo.

Test Plan:
- Single byte: drive frame 0xA5 at CLKS_PER_BIT=16 → empty falls about 154 cycles after the start edge; rd_data=32'h0000_00A5; count=1; rd_en pulse → empty=1, rd_data=32'hFFFF_FFFF.
- Glitch rejection: rx low for 5 cycles, then high → no byte stored; FSM back in IDLE; empty stays 1.
- Framing error: frame 0x3C with stop bit low → frame_err=1, FIFO still empty; clr_err pulse → frame_err=0.
- Fill and overrun: send 17 bytes 0x00..0x10 without reading at FIFO_DEPTH=16 → full=1, count=16, overrun=1; pops return 0x00..0x0F in order; 0x10 is lost.
- Simultaneous push/pop at full: with 16 stored, assert rd_en in the push cycle → count stays 16; overrun=0; last entry is the new byte.
- Async reset mid-frame: assert reset during DATA bit 3 of 0xFF, release → all outputs at reset values; the next full frame 0x42 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the empty-read value
// that the transmit peripheral and the load-path mux both return.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam logic [31:0] EMPTY_READ     = 32'hFFFF_FFFF;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop on a full FIFO frees the slot for a
// same-cycle push, and pops on an empty FIFO are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);
    assign dout      = mem[rd_ptr];
    assign count     = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push_c && !do_pop_c) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop_c && !do_push_c) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO read by the load path; sticky frame/overrun
// flags with a clear strobe.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [31:0]                   rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clr_err
);

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned BIT_W    = $clog2(UART_DATA_BITS);

    rx_state_e                 state;
    logic [1:0]                sync_q;
    logic [1:0]                settle_q;
    logic                      rx_s;
    logic                      armed;
    logic [CNT_W-1:0]          clk_cnt;
    logic [BIT_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] head;
    logic                      bit_end_c;
    logic                      push_c;
    logic                      frame_c;
    logic                      overrun_c;

    assign rx_s      = sync_q[1];
    assign bit_end_c = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign push_c    = (state == STOP) && bit_end_c && rx_s;
    assign frame_c   = (state == STOP) && bit_end_c && !rx_s;
    assign overrun_c = push_c && full && !rd_en;
    assign rd_data   = empty ? EMPTY_READ : 32'(head);

    // settle_q keeps the reset value of the synchroniser from arming a start detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= 2'b11;
            settle_q <= 2'b00;
        end else begin
            sync_q   <= {sync_q[0], rx};
            settle_q <= {settle_q[0], 1'b1};
        end
    end

    // Bit-timing FSM; a start is only taken from a line seen high while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            armed   <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (rx_s) begin
                        armed <= settle_q[1];
                    end else if (armed) begin
                        armed <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (clk_cnt == CNT_W'(HALF_BIT - 1)) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end_c) begin
                        clk_cnt <= '0;
                        shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + BIT_W'(1);
                        if (bit_idx == BIT_W'(UART_DATA_BITS - 1)) begin
                            state <= STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end_c) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flags; a new event outranks a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_c) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (overrun_c) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .pop   (rd_en),
        .din   (shift_q),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed and random 8N1 frames against a queue-based model
// that is compared with every output on each falling clock edge.
module tb_uart_rx_fifo;

    localparam int unsigned CLKS  = 16;
    localparam int unsigned DEPTH = 16;
    // Rising edges from the first edge after the line falls to the edge that stores the byte.
    localparam int unsigned LAT   = 2 + CLKS / 2 + 9 * CLKS;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        rd_en;
    logic        clr_err;
    logic [31:0] rd_data;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        frame_err;
    logic        overrun;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  data;
        logic        ok;
    } sched_t;

    sched_t      sched[$];
    logic [7:0]  mq[$];
    logic        m_fe = 1'b0;
    logic        m_ov = 1'b0;
    int unsigned cyc = 0;
    bit          cmp_en = 1'b0;
    bit          done = 1'b0;
    int unsigned rd_div = 500;
    int          n_chk = 0;
    int          n_err = 0;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CLKS),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frames complete at their scheduled edge, pops take the head first.
    always @(posedge clk) begin
        sched_t e;
        logic   pop;
        logic   fe_ev;
        logic   ov_ev;
        logic   do_push;
        cyc++;
        if (!reset) begin
            mq.delete();
            sched.delete();
            m_fe = 1'b0;
            m_ov = 1'b0;
        end else begin
            pop     = rd_en && (mq.size() > 0);
            fe_ev   = 1'b0;
            ov_ev   = 1'b0;
            do_push = 1'b0;
            e       = '{cyc: 0, data: 8'h00, ok: 1'b0};
            if (sched.size() > 0 && sched[0].cyc == cyc) begin
                e = sched.pop_front();
                if (!e.ok) fe_ev = 1'b1;
                else if (mq.size() == DEPTH && !pop) ov_ev = 1'b1;
                else do_push = 1'b1;
            end
            if (pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e.data);
            m_fe = fe_ev | (m_fe & ~clr_err);
            m_ov = ov_ev | (m_ov & ~clr_err);
        end
    end

    always @(negedge clk) begin
        logic [31:0] exp_rd;
        if (cmp_en && reset) begin
            exp_rd = 32'hFFFF_FFFF;
            if (mq.size() > 0) exp_rd = {24'h0, mq[0]};
            chk("rd_data", rd_data, exp_rd);
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("count", 32'(count), 32'(mq.size()));
            chk("frame_err", 32'(frame_err), 32'(m_fe));
            chk("overrun", 32'(overrun), 32'(m_ov));
        end
    end

    // Caller is at a falling edge; returns at a falling edge after the stop bit and a short gap.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        sched.push_back('{cyc: cyc + 1 + LAT, data: d, ok: stop});
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CLKS) @(negedge clk);
        end
        rx = stop;
        repeat (CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_data"}, rd_data, 32'hFFFF_FFFF);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        rx      = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        reset  = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte with exact store latency.
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (LAT) @(negedge clk);
                chk("a5_empty_before", 32'(empty), 32'd1);
                @(negedge clk);
                chk("a5_empty_after", 32'(empty), 32'd0);
            end
        join
        chk("a5_rd_data", rd_data, 32'h0000_00A5);
        chk("a5_count", 32'(count), 32'd1);
        pop_one();
        chk("a5_pop_empty", 32'(empty), 32'd1);
        chk("a5_pop_rd_data", rd_data, 32'hFFFF_FFFF);

        // Glitch shorter than half a bit, then a real frame.
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_empty", 32'(empty), 32'd1);
        send_frame(8'h5C, 1'b1);
        chk("after_glitch_rd", rd_data, 32'h0000_005C);
        pop_one();

        // Framing error.
        send_frame(8'h3C, 1'b0);
        chk("fe_set", 32'(frame_err), 32'd1);
        chk("fe_empty", 32'(empty), 32'd1);
        pulse_clr();
        chk("fe_clr", 32'(frame_err), 32'd0);

        // Fill past depth.
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_overrun", 32'(overrun), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("fill_order", rd_data, 32'(i));
            pop_one();
        end
        chk("fill_drained", 32'(empty), 32'd1);
        pulse_clr();
        chk("ov_clr", 32'(overrun), 32'd0);

        // Push coinciding with a pop while full.
        for (int i = 0; i < 16; i++) send_frame(8'h80 + 8'(i), 1'b1);
        fork
            send_frame(8'h5A, 1'b1);
            begin
                repeat (LAT) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        chk("pp_count", 32'(count), 32'd16);
        chk("pp_overrun", 32'(overrun), 32'd0);
        chk("pp_head", rd_data, 32'h0000_0081);
        for (int i = 0; i < 15; i++) pop_one();
        chk("pp_last", rd_data, 32'h0000_005A);

        // Reset during data bit 3 of 0xFF, with a byte still stored.
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CLKS + CLKS / 2) @(negedge clk);
        cmp_en = 1'b0;
        reset  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("mid_rst");
        reset = 1'b1;
        repeat (6 * CLKS) @(negedge clk);
        cmp_en = 1'b1;
        chk_reset_vals("post_rst");
        send_frame(8'h42, 1'b1);
        chk("post_rst_rd", rd_data, 32'h0000_0042);
        chk("post_rst_count", 32'(count), 32'd1);

        // Random frames: a slow-read phase that overflows, then a fast-read phase.
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    rd_div = (k < 18) ? 500 : 4;
                    send_frame(8'($urandom), $urandom_range(0, 7) != 0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rd_en   = ($urandom_range(0, rd_div - 1) == 0);
                    clr_err = ($urandom_range(0, 300) == 0);
                    @(negedge clk);
                end
            end
        join
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
